// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
//   Load/store unit front end. Takes one memory request at a time from the
//   pipeline, performs a single-cycle access to a byte-lane RAM with
//   combinational read data, and returns an in-order response.
//   Loads return sign- or zero-extended data; stores return zero.
//   Misaligned or reserved-size requests are answered without touching RAM.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid_i/ready_o : request handshake (ready only while idle)
//   req_op_i            : [3] store, [2] unsigned load, [1:0] size (b/h/w/rsv)
//   req_addr_i          : byte address
//   req_wdata_i         : store data in the low bits
//   req_rd_i            : destination register tag, echoed in the response
//   resp_valid_o/ready_i: response handshake
//   resp_rdata_o        : extended load data (0 for stores and errors)
//   resp_rd_o           : echoed tag
//   resp_ale_o          : address-misaligned flag
//   ram_en_o/we_o/re_o  : RAM strobes, active only during the access cycle
//   ram_addr_o          : word-aligned RAM address
//   ram_sel_o           : byte-lane enables
//   ram_wdata_o         : lane-replicated store data
//   ram_rdata_i         : RAM read data, valid in the same cycle as the address
// ----------------------------------------------------------------------------
module data_mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_ale_o,
  output logic        ram_en_o,
  output logic        ram_we_o,
  output logic        ram_re_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [31:0] r_rdata;
  logic        r_ale;

  logic        w_accept;
  logic        w_reserved;
  logic        w_misal;

  function automatic logic [3:0] f_sel(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_sel = 4'b0001 << lo;
      2'b01:   f_sel = 4'b0011 << lo;
      2'b10:   f_sel = 4'b1111;
      default: f_sel = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] op, input logic [1:0] lo,
                                         input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (op[1:0])
      2'b00:   f_load = op[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   f_load = op[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: f_load = rdata;
    endcase
  endfunction

  assign w_accept   = req_valid_i & req_ready_o;
  assign w_reserved = (req_op_i[1:0] == 2'b11);
  // Only half and word sizes can be misaligned; reserved sizes never flag ale.
  assign w_misal    = ((req_op_i[1:0] == 2'b01) & req_addr_i[0]) |
                      ((req_op_i[1:0] == 2'b10) & (req_addr_i[1:0] != 2'b00));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Request / response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
      r_ale   <= 1'b0;
    end else if (w_accept) begin
      r_op    <= req_op_i;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_rd    <= req_rd_i;
      r_rdata <= '0;
      r_ale   <= w_misal;
    end else if (r_state == S_ACCESS && !r_op[3]) begin
      r_rdata <= f_load(r_op[2:0], r_addr[1:0], ram_rdata_i);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (w_misal | w_reserved) ? S_RESP : S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   if (resp_ready_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs: everything is forced low while reset is held, which also
  // suppresses a store strobe if reset lands in the access cycle.
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_rd_o    = '0;
    resp_ale_o   = 1'b0;
    ram_en_o     = 1'b0;
    ram_we_o     = 1'b0;
    ram_re_o     = 1'b0;
    ram_addr_o   = '0;
    ram_sel_o    = '0;
    ram_wdata_o  = '0;
    if (!rst) begin
      case (r_state)
        S_IDLE: req_ready_o = 1'b1;
        S_ACCESS: begin
          ram_en_o   = 1'b1;
          ram_we_o   = r_op[3];
          ram_re_o   = ~r_op[3];
          ram_addr_o = {r_addr[31:2], 2'b00};
          ram_sel_o  = f_sel(r_op[1:0], r_addr[1:0]);
          if (r_op[3]) ram_wdata_o = f_wdata(r_op[1:0], r_wdata);
        end
        S_RESP: begin
          resp_valid_o = 1'b1;
          resp_rdata_o = r_rdata;
          resp_rd_o    = r_rd;
          resp_ale_o   = r_ale;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_op_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic [4:0]  resp_rd_o;
  logic        resp_ale_o;
  logic        ram_en_o, ram_we_o, ram_re_o;
  logic [31:0] ram_addr_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int nassert = 0;
  int nfail   = 0;

  // RAM attached to the controller (word array, byte-lane writes)
  logic [31:0] ram [256];
  logic        mem_clr;
  // Reference memory: plain byte array updated from request semantics
  logic [7:0]  ref_mem [1024];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o), .resp_ale_o(resp_ale_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_re_o(ram_re_o),
    .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i)
  );

  assign ram_rdata_i = ram[ram_addr_o[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
    end else if (ram_en_o && ram_we_o) begin
      for (int l = 0; l < 4; l++)
        if (ram_sel_o[l]) ram[ram_addr_o[9:2]][8*l +: 8] <= ram_wdata_o[8*l +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int widx);
    ref_word = {ref_mem[4*widx+3], ref_mem[4*widx+2], ref_mem[4*widx+1], ref_mem[4*widx]};
  endfunction

  // One complete request/response transaction, checked against the model.
  task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [4:0] rd, input int hold, output logic [31:0] obs);
    int          nb;
    int          base;
    int          sz;
    logic        exp_ale;
    logic        bad;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wd;
    logic [31:0] held;
    sz      = int'(op[1:0]);
    nb      = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    base    = int'(addr[9:0]);
    exp_ale = (sz == 1 && base % 2 != 0) || (sz == 2 && base % 4 != 0);
    bad     = exp_ale || sz == 3;
    exp_rd  = 32'h0;
    exp_sel = 4'h0;
    exp_wd  = 32'h0;
    if (!bad) begin
      for (int i = 0; i < nb; i++) begin
        exp_sel[(base % 4) + i] = 1'b1;
        if (!op[3]) exp_rd = exp_rd | (32'(ref_mem[base + i]) << (8 * i));
      end
      if (!op[3] && nb < 4 && !op[2] && exp_rd[8*nb-1])
        exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * nb));
      for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
    end

    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
    chk("req_ready_idle", 32'(req_ready_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    if (bad) begin
      chk("bad_no_ram_en", 32'(ram_en_o), 32'd0);
      chk("bad_resp_latency", 32'(resp_valid_o), 32'd1);
    end else begin
      chk("acc_ram_en", 32'(ram_en_o), 32'd1);
      chk("acc_ram_we", 32'(ram_we_o), 32'(op[3]));
      chk("acc_ram_re", 32'(ram_re_o), 32'(!op[3]));
      chk("acc_ram_addr", ram_addr_o, {addr[31:2], 2'b00});
      chk("acc_ram_sel", 32'(ram_sel_o), 32'(exp_sel));
      if (op[3]) chk("acc_ram_wdata", ram_wdata_o, exp_wd);
      chk("acc_no_resp", 32'(resp_valid_o), 32'd0);
      @(negedge clk);
      chk("resp_ram_en_off", 32'(ram_en_o), 32'd0);
      chk("resp_latency", 32'(resp_valid_o), 32'd1);
    end
    held = resp_rdata_o;
    for (int h = 0; h < hold; h++) begin
      req_valid_i = 1'b1;  // stray request, must be ignored outside IDLE
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid_o), 32'd1);
      chk("hold_rdata", resp_rdata_o, held);
      chk("hold_ready_low", 32'(req_ready_o), 32'd0);
      chk("hold_ram_en", 32'(ram_en_o), 32'd0);
    end
    chk("resp_rdata", resp_rdata_o, exp_rd);
    chk("resp_rd", 32'(resp_rd_o), 32'(rd));
    chk("resp_ale", 32'(resp_ale_o), 32'(exp_ale));
    obs = resp_rdata_o;
    resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready_i = 1'b0;
    chk("after_hs_valid", 32'(resp_valid_o), 32'd0);
    chk("after_hs_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b0;
    if (op[3] && !bad)
      for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [3:0]  op;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    rst = 1'b1; mem_clr = 1'b1;
    req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0; req_rd_i = '0;
    resp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rst_ram_sel", 32'(ram_sel_o), 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    chk("rst_resp_rdata", resp_rdata_o, 32'd0);
    req_valid_i = 1'b0;
    rst = 1'b0; mem_clr = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Word store then load
    xact(4'b1010, 32'h100, 32'h1122_3344, 5'd1, 0, r);
    xact(4'b0010, 32'h100, 32'h0, 5'd2, 0, r);
    chk("ldw_0x100", r, 32'h1122_3344);
    // Byte store, signed and unsigned byte loads
    xact(4'b1000, 32'h203, 32'h0000_00F0, 5'd3, 0, r);
    chk("stb_resp_zero", r, 32'h0);
    xact(4'b0000, 32'h203, 32'h0, 5'd4, 0, r);
    chk("ldb_0x203", r, 32'hFFFF_FFF0);
    xact(4'b0100, 32'h203, 32'h0, 5'd5, 0, r);
    chk("ldbu_0x203", r, 32'h0000_00F0);
    // Half store then signed half load
    xact(4'b1001, 32'h302, 32'h0000_8001, 5'd6, 0, r);
    xact(4'b0001, 32'h302, 32'h0, 5'd7, 0, r);
    chk("ldh_0x302", r, 32'hFFFF_8001);
    // Misaligned word load
    xact(4'b0010, 32'h101, 32'h0, 5'd8, 0, r);
    chk("misal_rdata", r, 32'h0);
    // Reserved size
    xact(4'b0011, 32'h104, 32'h0, 5'd9, 1, r);
    // Back-pressure: response held for 5 cycles
    xact(4'b0010, 32'h100, 32'h0, 5'd10, 5, r);
    chk("ldw_hold", r, 32'h1122_3344);

    // Reset during a store's access cycle
    xact(4'b1010, 32'h180, 32'hCAFE_F00D, 5'd11, 0, r);
    @(negedge clk);
    req_valid_i = 1'b1; req_op_i = 4'b1010; req_addr_i = 32'h180;
    req_wdata_i = 32'hDEAD_BEEF; req_rd_i = 5'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_acc_we", 32'(ram_we_o), 32'd0);
    chk("rst_acc_en", 32'(ram_en_o), 32'd0);
    chk("rst_acc_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_acc_idle", 32'(req_ready_o), 32'd1);
    chk("rst_acc_no_resp", 32'(resp_valid_o), 32'd0);
    chk("rst_acc_ram_kept", ram[32'h180 >> 2], ref_word(32'h180 >> 2));
    xact(4'b0010, 32'h180, 32'h0, 5'd13, 0, r);
    chk("rst_acc_readback", r, 32'hCAFE_F00D);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 80; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (op[1:0] == 2'b01) a[0] = 1'b0;
        if (op[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      xact(op, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port req_valid_i, input, 1, pipeline presents a memory request.
REQ-004 SHALL have port req_ready_o, output, 1, controller accepts a request this cycle.
REQ-005 SHALL have port req_op_i, input, 4, operation: bit3 = store, bit2 = unsigned (loads only), bits1:0 = size (00 byte, 01 half, 10 word, 11 reserved).
REQ-006 SHALL have ports req_addr_i (input, 32, byte address), req_wdata_i (input, 32, store data in low bits) and req_rd_i (input, 5, destination register tag).
REQ-007 SHALL have ports resp_valid_o (output, 1), resp_ready_i (input, 1), resp_rdata_o (output, 32, extended load data), resp_rd_o (output, 5, echoed tag) and resp_ale_o (output, 1, address-misaligned flag).
REQ-008 SHALL have RAM-side ports ram_en_o, ram_we_o, ram_re_o (output, 1 each), ram_addr_o (output, 32), ram_sel_o (output, 4, byte lanes), ram_wdata_o (output, 32) and ram_rdata_i (input, 32, combinational read data valid in the same cycle as the address).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-010 SHALL drive req_ready_o = 1 only in IDLE; a request is accepted on a clock edge where req_valid_i and req_ready_o are both 1, and op, address, wdata and tag are registered.
REQ-011 SHALL move from IDLE to ACCESS on an accepted, aligned request with a non-reserved size.
REQ-012 SHALL move from IDLE directly to RESP on a misaligned or reserved-size request, with no RAM access.
- Misaligned: half with addr[0] = 1, or word with addr[1:0] != 0.
- Response for misaligned: ale = 1.
- Response for reserved size: ale = 0, rdata = 0.
REQ-013 SHALL, in ACCESS and for exactly one cycle, assert ram_en_o = 1 and ram_addr_o = {addr[31:2], 2'b00}.
- Stores: ram_we_o = 1, ram_re_o = 0.
- Loads: ram_re_o = 1, ram_we_o = 0.
REQ-014 SHALL then go ACCESS -> RESP unconditionally; load data is captured from ram_rdata_i at that edge.
REQ-015 SHALL generate ram_sel_o as follows:
- byte: 4'b0001 << addr[1:0];
- half: 4'b0011 << addr[1:0];
- word: 4'b1111.
- ram_sel_o = 0 outside ACCESS.
REQ-016 SHALL replicate store data as follows: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-017 SHALL extract load data as follows:
- byte: ram_rdata_i >> (8*addr[1:0]);
- half: ram_rdata_i >> (16*addr[1]);
- result is sign-extended to 32 bits when bit2 = 0 and zero-extended when bit2 = 1; word ignores bit2.
REQ-018 SHALL, in RESP, hold resp_valid_o = 1 with stable rdata, rd and ale until resp_ready_i = 1, then return to IDLE on that edge.
REQ-019 SHALL also produce a response for stores, with resp_rdata_o = 0, so that responses stay strictly in request order; at most one request is outstanding.
REQ-020 SHALL give load and store latency as follows: accept at edge N, resp_valid_o high in the cycle after edge N+1; a misaligned or reserved request is answered in the cycle after edge N.
REQ-021 SHALL keep all ram_* outputs at 0 whenever the state is not ACCESS.
REQ-022 SHALL ignore req_valid_i while not in IDLE; no request is accepted in the same cycle a response handshake completes.

Reset
REQ-023 SHALL, on an edge where rst = 1, enter IDLE and clear the registered op, addr, wdata, rd and response data to 0.
REQ-024 SHALL, while rst = 1, hold all outputs at 0 (req_ready_o = 0, resp_valid_o = 0, ram_en_o = ram_we_o = ram_re_o = 0, ram_sel_o = 0, ram_addr_o = ram_wdata_o = 0, resp_rdata_o = resp_rd_o = resp_ale_o = 0).
REQ-025 SHALL ensure that reset asserted during ACCESS suppresses ram_en_o and ram_we_o in that cycle, so no partial store is committed; a pending response is discarded.

Verification
REQ-026 SHALL pass this scenario: ST.W addr 0x100 data 0x11223344, then LD.W 0x100 -> ram_sel_o = 1111; load resp_rdata_o = 0x11223344, resp_ale_o = 0.
REQ-027 SHALL pass this scenario: ST.B addr 0x203 data 0x000000F0, then LD.B 0x203 and LD.BU 0x203 -> ram_sel_o = 1000, ram_wdata_o = 0xF0F0F0F0; responses 0xFFFFFFF0 and 0x000000F0.
REQ-028 SHALL pass this scenario: ST.H addr 0x302 data 0x8001, then LD.H 0x302 -> ram_sel_o = 1100; response 0xFFFF8001.
REQ-029 SHALL pass this scenario: LD.W addr 0x101 -> no ram_en_o pulse; resp_valid_o one cycle after accept with resp_ale_o = 1.
REQ-030 SHALL pass this scenario: LD.W accepted, resp_ready_i held 0 for 5 cycles -> resp_valid_o and resp_rdata_o stable throughout; req_ready_o = 0; completes on the first resp_ready_i = 1 edge.
REQ-031 SHALL pass this scenario: ST.W accepted, rst = 1 during ACCESS -> ram_we_o = 0 in that cycle; RAM contents unchanged; FSM in IDLE with req_ready_o = 1 once rst = 0.
